// File: rtl/vga_capture.sv
// VGA receiver: resynchronises hs/vs/rgb onto clk_50, recovers pixel position,
// emits a raster-order frame-buffer write stream and tracks line/frame timing lock.
module vga_capture #(
    parameter int CLK_PER_PIX = 2,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic        r,
    input  logic        g,
    input  logic        b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic [18:0] wr_addr,
    output logic        frame_start,
    output logic        frame_done,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
);

    localparam int PH_W = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
    localparam int GC_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [PH_W-1:0] PH_TICK   = PH_W'(CLK_PER_PIX / 2);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_PER_PIX - 1);
    localparam logic [9:0]      H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]      H_END     = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0]      H_LEN     = 10'(H_TOTAL);
    localparam logic [9:0]      H_TIMEOUT = 10'(H_TOTAL + 16);
    localparam logic [9:0]      V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]      V_END     = 10'(V_SYNC + V_BP + V_ACT);
    localparam logic [9:0]      V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]      CNT_MAX   = 10'h3FF;
    localparam logic [18:0]     ADDR_MAX  = 19'(H_ACT * V_ACT - 1);
    localparam logic [GC_W-1:0] LOCK_C    = GC_W'(LOCK_FRAMES);

    logic [1:0]      hs_sync, vs_sync;
    logic            hs_d, vs_d;
    logic [2:0]      rgb_m, rgb_s;
    logic [PH_W-1:0] phase_q, phase;
    logic [9:0]      h_cnt, v_cnt;
    logic [18:0]     addr;
    logic [GC_W-1:0] good_cnt;
    logic            vs_pend, aligned, seen_hs, timed_out, frame_bad;
    logic            hs_fall, vs_fall, tick, realign, active;
    logic            line_len_bad, timeout_hit, line_err_now, frame_err_now;

    // Sync registers idle high so reset never fakes a sync falling edge.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            hs_sync <= 2'b11;
            vs_sync <= 2'b11;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            rgb_m   <= '0;
            rgb_s   <= '0;
        end else begin
            hs_sync <= {hs_sync[0], hs};
            vs_sync <= {vs_sync[0], vs};
            hs_d    <= hs_sync[1];
            vs_d    <= vs_sync[1];
            rgb_m   <= {r, g, b};
            rgb_s   <= rgb_m;
        end
    end

    assign hs_fall = hs_d & ~hs_sync[1];
    assign vs_fall = vs_d & ~vs_sync[1];
    assign phase   = hs_fall ? '0 : phase_q;
    assign tick    = (phase == PH_TICK);
    assign realign = hs_fall & (vs_pend | vs_fall);

    // h_cnt has already advanced past the last pixel when the next hs falls.
    assign line_len_bad  = hs_fall & seen_hs & ~timed_out & (h_cnt != H_LEN);
    assign timeout_hit   = seen_hs & ~timed_out & (h_cnt == H_TIMEOUT);
    assign line_err_now  = line_len_bad | timeout_hit;
    assign frame_err_now = realign & aligned & (v_cnt != V_LAST);

    assign active = tick & aligned &
                    (h_cnt >= H_START) & (h_cnt < H_END) &
                    (v_cnt >= V_START) & (v_cnt < V_END);

    assign locked = (good_cnt == LOCK_C);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            phase_q   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            vs_pend   <= 1'b0;
            aligned   <= 1'b0;
            seen_hs   <= 1'b0;
            timed_out <= 1'b0;
            addr      <= '0;
            frame_bad <= 1'b0;
            good_cnt  <= '0;
        end else begin
            phase_q <= (phase == PH_LAST) ? '0 : phase + 1'b1;

            if (hs_fall) begin
                h_cnt   <= '0;
                seen_hs <= 1'b1;
            end else if (tick && h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 1'b1;
            end

            if (hs_fall)
                timed_out <= 1'b0;
            else if (timeout_hit)
                timed_out <= 1'b1;

            if (realign) begin
                v_cnt   <= '0;
                vs_pend <= 1'b0;
                aligned <= 1'b1;
            end else begin
                if (vs_fall)
                    vs_pend <= 1'b1;
                if (hs_fall && v_cnt != CNT_MAX)
                    v_cnt <= v_cnt + 1'b1;
            end

            if (realign)
                addr <= '0;
            else if (active && addr != ADDR_MAX)
                addr <= addr + 1'b1;

            // An error at the realign edge belongs to the frame that just ended.
            if (line_err_now || frame_err_now) begin
                good_cnt  <= '0;
                frame_bad <= ~realign;
            end else if (realign) begin
                frame_bad <= 1'b0;
                if (aligned && !frame_bad && good_cnt != LOCK_C)
                    good_cnt <= good_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            wr_addr     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pix_valid   <= active;
            frame_start <= active & (addr == '0);
            frame_done  <= active & (addr == ADDR_MAX);
            line_err    <= line_err_now;
            frame_err   <= frame_err_now;
            if (active) begin
                pix_x   <= h_cnt - H_START;
                pix_y   <= 9'(v_cnt - V_START);
                pix_rgb <= rgb_s;
                wr_addr <= addr;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a reduced raster (20x10 pixels, 8x4 active) so
// many frames, errors and recovery fit in a short run.
module tb_vga_capture;
    localparam int CPP = 2;
    localparam int HS  = 4;
    localparam int HBP = 3;
    localparam int HA  = 8;
    localparam int HT  = 20;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int VA  = 4;
    localparam int VT  = 10;
    localparam int LF  = 2;
    localparam int W   = 43;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
    logic        pix_valid, frame_start, frame_done, locked, line_err, frame_err;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [2:0]  pix_rgb;
    logic [18:0] wr_addr;

    int n_checks = 0;
    int n_errors = 0;
    int le_cnt = 0;
    int fe_cnt = 0;
    int frame_pix = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    vga_capture #(
        .CLK_PER_PIX(CPP), .H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk_50(clk_50), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .wr_addr(wr_addr), .frame_start(frame_start), .frame_done(frame_done),
        .locked(locked), .line_err(line_err), .frame_err(frame_err)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every captured pixel must match the oldest expected entry.
    always @(negedge clk_50) begin
        if (line_err) le_cnt++;
        if (frame_err) fe_cnt++;
        if (pix_valid) begin
            frame_pix++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 64'(pix_valid), 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check_eq("pixel", 64'({frame_start, frame_done, pix_rgb, pix_y, pix_x, wr_addr}),
                         64'(exp_e));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq(tag, 64'({pix_valid, pix_x, pix_y, pix_rgb, wr_addr, frame_start,
                           frame_done, locked, line_err, frame_err}), 64'd0);
    endtask

    task automatic drive_line(input int line, input int len, input bit vs_low,
                              input bit expect_en, input int rst_pix, input bit sync_en);
        logic [2:0]  rgb;
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [18:0] ea;
        for (int p = 0; p < len; p++) begin
            hs = !(sync_en && p < HS);
            vs = !vs_low;
            rgb = 3'($urandom_range(0, 7));
            {r, g, b} = rgb;
            if (expect_en && line >= VS + VBP && line < VS + VBP + VA &&
                p >= HS + HBP && p < HS + HBP + HA) begin
                ex = 10'(p - (HS + HBP));
                ey = 9'(line - (VS + VBP));
                ea = 19'(int'(ey) * HA + int'(ex));
                exp_q.push_back({ea == 19'd0, ea == 19'(HA * VA - 1), rgb, ey, ex, ea});
            end
            if (p == rst_pix) begin
                rst = 1'b1;
                @(posedge clk_50); #1;
                rst = 1'b0;
                check_all_zero("midframe_reset_outputs");
                check_eq("midframe_reset_queue", 64'(exp_q.size()), 64'd0);
            end else begin
                @(posedge clk_50); #1;
            end
            @(posedge clk_50); #1;
        end
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input int rst_line);
        bit full;
        full = (rst_line < 0);
        frame_pix = 0;
        for (int l = 0; l < nlines; l++) begin
            drive_line(l, (l == short_line) ? HT - 1 : HT, l < VS,
                       !(rst_line >= 0 && l >= rst_line), (l == rst_line) ? 5 : -1, 1'b1);
        end
        if (full) begin
            check_eq("frame_pixel_count", 64'(frame_pix), 64'(HA * VA));
            check_eq("frame_queue_drained", 64'(exp_q.size()), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(posedge clk_50);
        #1;
        check_eq("reset_pix_valid", 64'(pix_valid), 64'd0);
        check_eq("reset_wr_addr", 64'(wr_addr), 64'd0);
        check_eq("reset_locked", 64'(locked), 64'd0);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (6) begin @(posedge clk_50); #1; end

        // Nominal frames: lock after the second complete frame.
        drive_frame(VT, -1, -1);
        check_eq("locked_f1", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("locked_f2", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("locked_f3", 64'(locked), 64'd1);
        check_eq("nominal_line_err", 64'(le_cnt), 64'd0);
        check_eq("nominal_frame_err", 64'(fe_cnt), 64'd0);

        // One-clock phase shift between frames.
        @(posedge clk_50); #1;
        drive_frame(VT, -1, -1);
        check_eq("phase_line_err", 64'(le_cnt), 64'd0);
        check_eq("phase_locked", 64'(locked), 64'd1);

        // Short line, then relock after two good frames.
        drive_frame(VT, 8, -1);
        check_eq("short_line_err", 64'(le_cnt), 64'd1);
        check_eq("short_locked_drop", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("relock_f1", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("relock_f2", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("relock_f3", 64'(locked), 64'd1);

        // Frame missing one line.
        drive_frame(VT - 1, -1, -1);
        check_eq("badframe_pre_err", 64'(fe_cnt), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("badframe_err", 64'(fe_cnt), 64'd1);
        check_eq("badframe_locked", 64'(locked), 64'd0);
        check_eq("badframe_no_line_err", 64'(le_cnt), 64'd1);

        // Reset in the middle of an active line; nothing captured until realign.
        drive_frame(VT, -1, 5);
        check_eq("post_reset_locked", 64'(locked), 64'd0);
        drive_frame(VT, -1, -1);
        check_eq("post_reset_line_err", 64'(le_cnt), 64'd1);
        check_eq("post_reset_frame_err", 64'(fe_cnt), 64'd1);

        // Lost hs: a 50-pixel stretch with no sync pulse after a good frame.
        drive_frame(VT, -1, -1);
        drive_line(VT, 50, 1'b0, 1'b0, -1, 1'b0);
        check_eq("lost_hs_timeout", 64'(le_cnt), 64'd2);
        drive_frame(VT, -1, -1);
        check_eq("lost_hs_single_err", 64'(le_cnt), 64'd2);
        check_eq("lost_hs_frame_err", 64'(fe_cnt), 64'd1);
        check_eq("lost_hs_locked", 64'(locked), 64'd0);

        repeat (8) begin @(posedge clk_50); #1; end
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
